// File: rtl/fpmul_pkg.sv
// Shared types and constants for the fp32 multiplier arbiter.
// Exports fp32_t, arb_state_t and a few fp32 bit patterns.
package fpmul_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam fp32_t FP_ONE  = 32'h3f80_0000;
  localparam fp32_t FP_INF  = 32'h7f80_0000;
  localparam fp32_t FP_QNAN = 32'h7fc0_0000;

endpackage

// File: rtl/fpmul_arbiter_mul.sv
// Combinational IEEE-754 single multiply, round-to-nearest-even.
// Ports: a, b in; y out. Subnormals flush to signed zero.
module fp32_mul
  import fpmul_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t y
);

  logic              sign;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic              a_zero, b_zero;
  logic              a_inf, b_inf;
  logic              a_nan, b_nan;
  logic [47:0]       prod;
  logic signed [9:0] exp_s;
  logic [22:0]       mant;
  logic              guard;
  logic              sticky;
  logic [23:0]       rnd;
  logic [22:0]       mant_r;

  always_comb begin
    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hff) && (a[22:0] == '0);
    b_inf  = (eb == 8'hff) && (b[22:0] == '0);
    a_nan  = (ea == 8'hff) && (a[22:0] != '0);
    b_nan  = (eb == 8'hff) && (b[22:0] != '0);

    prod  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp_s = $signed({2'b00, ea}) + $signed({2'b00, eb})
          - 10'sd127;

    // Significand product lies in [1,4): normalise by one bit.
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    rnd = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
    if (rnd[23]) begin
      mant_r = '0;
      exp_s  = exp_s + 10'sd1;
    end else begin
      mant_r = rnd[22:0];
    end

    if (a_nan || b_nan) begin
      y = FP_QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      y = FP_QNAN;
    end else if (a_inf || b_inf) begin
      y = {sign, FP_INF[30:0]};
    end else if (a_zero || b_zero) begin
      y = {sign, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      y = {sign, FP_INF[30:0]};
    end else if (exp_s <= 10'sd0) begin
      y = {sign, 31'd0};
    end else begin
      y = {sign, exp_s[7:0], mant_r};
    end
  end

endmodule

// File: rtl/fpmul_arbiter_rr.sv
// Round-robin grant picker: first set req bit at or above ptr, wrapping.
// Ports: req, ptr in; grant_oh, grant_idx, any_req out. Combinational.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_oh,
  output logic [W-1:0] grant_idx,
  output logic         any_req
);

  localparam int WP = W + 1;
  localparam logic [WP-1:0] N_W = WP'(N);

  logic [WP-1:0] pos;
  logic          found;

  // ptr + k never exceeds 2N-2, so one subtraction wraps it.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + WP'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (!found && req[pos[W-1:0]]) begin
        found               = 1'b1;
        grant_oh[pos[W-1:0]] = 1'b1;
        grant_idx           = pos[W-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin sharing of one fp32 multiplier among NUM_REQ requesters.
// Ports: clk, rst; req_valid/ready/a/b per requester;
// resp_valid/ready/y/id; busy_cnt (counts with FPMUL_ARB_STATS_EN).
module fpmul_arbiter
  import fpmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_y,
  output logic [ID_W-1:0]      resp_id,
  output logic [31:0]          busy_cnt
);

  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  arb_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  fp32_t               op_a;
  fp32_t               op_b;
  logic [ID_W-1:0]     op_id;
  fp32_t               mul_y;

  fp32_t               a_arr [NUM_REQ];
  fp32_t               b_arr [NUM_REQ];

  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]     grant_idx;
  logic                any_req;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  rr_arbiter #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  fp32_mul mul (
    .a (op_a),
    .b (op_b),
    .y (mul_y)
  );

  // Reset wins over a same-cycle handshake, so it masks the grant.
  assign req_ready = (state == IDLE && !rst) ? grant_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_y     <= '0;
      resp_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            op_a   <= a_arr[grant_idx];
            op_b   <= b_arr[grant_idx];
            op_id  <= grant_idx;
            rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          resp_y     <= mul_y;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPMUL_ARB_STATS_EN
  logic [31:0] busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (state != IDLE && busy_q != 32'hffff_ffff) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cnt = busy_q;
`else
  assign busy_cnt = '0;
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a cycle-level reference model.
// Checks grants, response timing, products, ids and busy_cnt.
module tb_fpmul_arbiter;

`ifdef FPMUL_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   vld;
  logic [3:0]   req_ready;
  logic [31:0]  ta [4];
  logic [31:0]  tb_ [4];
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_y;
  logic [1:0]   resp_id;
  logic [31:0]  busy_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  assign req_a = {ta[3], ta[2], ta[1], ta[0]};
  assign req_b = {tb_[3], tb_[2], tb_[1], tb_[0]};

  fpmul_arbiter #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (vld),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .resp_id    (resp_id),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Hand-computed products of every operand pair the bench drives.
  function automatic logic [31:0] ref_prod(input logic [31:0] a,
                                           input logic [31:0] b);
    case ({a, b})
      {32'h3fc00000, 32'h40000000}: return 32'h40400000;
      {32'h00000000, 32'h3f800000}: return 32'h00000000;
      {32'h7f800000, 32'h3f800000}: return 32'h7f800000;
      {32'h3f800000, 32'h3f800000}: return 32'h3f800000;
      {32'h40400000, 32'h3f800000}: return 32'h40400000;
      {32'hc0000000, 32'h40400000}: return 32'hc0c00000;
      {32'h3f800000, 32'h7f7fffff}: return 32'h7f7fffff;
      {32'h7f7fffff, 32'h40000000}: return 32'h7f800000;
      default:                      return 32'hxxxxxxxx;
    endcase
  endfunction

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Reference model: one op in flight, response two cycles after
  // acceptance, round-robin pointer just past the last grant.
  bit          m_busy = 1'b0;
  int          m_ptr = 0;
  int          m_acc = 0;
  int          m_id = 0;
  logic [31:0] m_y = '0;
  int          m_cnt = 0;
  int          m_g;
  int          m_j;
  logic [3:0]  m_er;
  bit          m_rv;

  always @(negedge clk) begin
    if (chk_en) begin
      m_g  = -1;
      m_er = '0;
      if (!rst && !m_busy) begin
        for (int k = 0; k < 4; k++) begin
          m_j = (m_ptr + k) % 4;
          if (m_g < 0 && vld[m_j]) m_g = m_j;
        end
      end
      if (m_g >= 0) m_er[m_g] = 1'b1;
      m_rv = m_busy && (cyc - m_acc >= 2);
      chk("m_ready", 32'(req_ready), 32'(m_er));
      chk("m_resp_valid", 32'(resp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("m_resp_y", resp_y, m_y);
        chk("m_resp_id", 32'(resp_id), m_id);
      end
      chk("m_busy_cnt", busy_cnt, STATS ? m_cnt : 0);
      if (rst) begin
        m_busy = 1'b0;
        m_ptr  = 0;
        m_cnt  = 0;
      end else begin
        if (m_busy) m_cnt++;
        if (m_g >= 0) begin
          m_busy = 1'b1;
          m_acc  = cyc;
          m_id   = m_g;
          m_y    = ref_prod(ta[m_g], tb_[m_g]);
          m_ptr  = (m_g + 1) % 4;
        end else if (m_rv && resp_ready) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_grant(input int idx, output int gc,
                            output logic [3:0] rdy);
    bit got = 1'b0;
    gc  = -1;
    rdy = '0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        got = 1'b1;
        gc  = cyc;
        rdy = req_ready;
      end
    end
    chk("grant_wait", 32'(got), 32'd1);
    @(posedge clk);
    #1 vld[idx] = 1'b0;
  endtask

  task automatic issue(input int idx, input logic [31:0] a,
                       input logic [31:0] b, output int gc,
                       output logic [3:0] rdy);
    @(posedge clk);
    #1;
    ta[idx]  = a;
    tb_[idx] = b;
    vld[idx] = 1'b1;
    wait_grant(idx, gc, rdy);
  endtask

  task automatic wait_resp(output logic [31:0] y, output int id,
                           output int rc);
    bit got = 1'b0;
    y  = 'x;
    id = -1;
    rc = -1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        got = 1'b1;
        y   = resp_y;
        id  = int'(resp_id);
        rc  = cyc;
      end
    end
    chk("resp_wait", 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int          gc, gc2, rc, id;
    logic [3:0]  rdy;
    logic [31:0] y;
    int          gi [4];
    int          gcs [4];
    int          n;

    rst        = 1'b1;
    vld        = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ta[i]  = '0;
      tb_[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_y", resp_y, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_busy", busy_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1.5 * 2.0 from requester 0
    issue(0, 32'h3fc00000, 32'h40000000, gc, rdy);
    chk("t1_ready", 32'(rdy), 32'h1);
    wait_resp(y, id, rc);
    chk("t1_latency", rc - gc, 2);
    chk("t1_y", y, 32'h40400000);
    chk("t1_id", id, 0);
    @(negedge clk);
    chk("t1_busy", busy_cnt, STATS ? 32'd2 : 32'd0);

    // zero and infinity pass through
    issue(2, 32'h00000000, 32'h3f800000, gc, rdy);
    wait_resp(y, id, rc);
    chk("t2_zero_y", y, 32'h00000000);
    chk("t2_zero_id", id, 2);
    issue(1, 32'h7f800000, 32'h3f800000, gc, rdy);
    wait_resp(y, id, rc);
    chk("t2_inf_y", y, 32'h7f800000);
    chk("t2_inf_id", id, 1);

    // all requesters valid from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ta[i]  = 32'h3f800000;
      tb_[i] = 32'h3f800000;
      gi[i]  = -1;
      gcs[i] = -1;
    end
    vld = 4'hf;
    n   = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gi[n]  = oh2i(req_ready);
        gcs[n] = cyc;
        n++;
        @(posedge clk);
        #1 vld[gi[n-1]] = 1'b0;
      end
    end
    chk("t3_count", n, 4);
    for (int i = 0; i < 4; i++) chk("t3_order", gi[i], i);
    for (int i = 1; i < 4; i++)
      chk("t3_spacing", gcs[i] - gcs[i-1], 3);
    wait_resp(y, id, rc);
    chk("t3_last_y", y, 32'h3f800000);
    chk("t3_last_id", id, 3);

    // response back-pressure with a competing request
    resp_ready = 1'b0;
    issue(3, 32'h40400000, 32'h3f800000, gc, rdy);
    ta[1]  = 32'hc0000000;
    tb_[1] = 32'h40400000;
    vld[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(resp_valid), 32'd1);
      chk("t4_hold_y", resp_y, 32'h40400000);
      chk("t4_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_resp(y, id, rc);
    chk("t4_y", y, 32'h40400000);
    chk("t4_id", id, 3);
    wait_grant(1, gc2, rdy);
    chk("t4_idle_next", gc2 - rc, 1);
    wait_resp(y, id, rc);
    chk("t4_neg_y", y, 32'hc0c00000);

    // reset while executing discards the op and the pointer
    do_reset();
    issue(0, 32'h3f800000, 32'h7f7fffff, gc, rdy);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    ta[2]  = 32'h7f7fffff;
    tb_[2] = 32'h40000000;
    vld[0] = 1'b1;
    vld[2] = 1'b1;
    wait_grant(0, gc, rdy);
    chk("t5_first", 32'(rdy), 32'h1);
    wait_resp(y, id, rc);
    chk("t5_max_y", y, 32'h7f7fffff);
    chk("t5_max_id", id, 0);
    wait_grant(2, gc, rdy);
    wait_resp(y, id, rc);
    chk("t5_ovf_y", y, 32'h7f800000);
    chk("t5_ovf_id", id, 2);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
Shares one combinational single-precision IEEE-754 multiplier (`mul`) between NUM_REQ requesters. Requesters use valid/ready handshakes. Arbitration is round-robin. Each accepted operation flows through a 3-state controller: accept, execute, respond. The product returns on one response channel, tagged with the requester index. The block sits between the FP consumers and the single `mul` instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, $clog2(NUM_REQ), width of the requester tag (minimum 1)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_a  input  NUM_REQ*32  operand A, requester i at bits [32*i+31:32*i]
req_b  input  NUM_REQ*32  operand B, same packing as req_a
resp_valid  output  1  product available
resp_ready  input  1  consumer accepts the product
resp_y  output  32  product bits
resp_id  output  ID_W  index of the requester that owns resp_y
busy_cnt  output  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_y=0, resp_id=0, busy_cnt=0.
- State IDLE:
  - If req_valid is nonzero, grant = first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in this cycle; the handshake completes in this cycle.
  - Latch op_a/op_b from the granted slice and op_id=grant.
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - Next state = EXEC.
  - If req_valid is zero, stay in IDLE; req_ready is all zero.
- State EXEC: drive the `mul` instance from op_a/op_b. Register y into resp_y and op_id into resp_id. Next state = RESP. req_ready is all zero.
- State RESP:
  - resp_valid=1; resp_y and resp_id are held stable until the handshake.
  - When resp_valid and resp_ready are both 1, go to IDLE; resp_valid falls on the next cycle.
  - No new request is accepted while in RESP.
- Latency: accept edge to resp_valid high is 2 cycles. Minimum initiation interval is 3 cycles per operation.
- req_ready never depends on resp_ready. req_ready is only asserted in IDLE.
- Requesters must hold operands stable while req_valid=1 and req_ready=0. Dropping valid before the grant is permitted and simply removes the request.
- Fairness: with all requesters valid continuously, grants cycle 0,1,2,...,NUM_REQ-1,0,...
- Arithmetic: the product is exactly the combinational `mul` output. The controller does no rounding or special-case handling. Zero, Inf and NaN pass through as `mul` produces them.
- rst asserted in any state: the in-flight operation is discarded, with no response. All outputs and rr_ptr return to their reset values on the next edge.
- rst has priority over a simultaneous handshake.

Optional Feature:
Macro: FPMUL_ARB_STATS_EN.
- Defined: busy_cnt increments by 1 on every cycle where state != IDLE. It saturates at 32'hFFFFFFFF and clears on rst.
- Undefined: busy_cnt is tied to 0 and no counter flops are generated.
- The port list is identical in both builds.

Decomposition:
- Package fpmul_pkg:
  - typedef fp32_t (logic [31:0]).
  - Enum arb_state_t {IDLE, EXEC, RESP}, 2-bit.
  - Constants FP_ONE=32'h3f800000, FP_INF=32'h7f800000.
- Sub-module rr_arbiter: parameter N. Inputs req[N] and ptr. Outputs a one-hot grant, a grant index and any_req. Purely combinational.
- The controller FSM, the operand/response registers and the `mul` instance live in fpmul_arbiter.

Test Plan:
1. Req0 valid, a=3fc00000, b=40000000, resp_ready=1 -> req_ready[0] in the accept cycle; 2 cycles later resp_valid=1, resp_y=40400000, resp_id=0.
2. Req2 only, a=00000000, b=3f800000, then req1 a=7f800000, b=3f800000 -> resp_y=00000000 with id 2, then 7f800000 with id 1.
3. All four requesters valid with a=3f800000, b=3f800000, held for 4 ops -> grant order 0,1,2,3; each resp_y=3f800000; each accept 3 cycles apart.
4. resp_ready=0 for 5 cycles in RESP with a=40400000, b=3f800000 -> resp_valid and resp_y=40400000 held stable; no req_ready pulses; IDLE is reached after resp_ready rises.
5. rst asserted during EXEC -> the next cycle has resp_valid=0 and rr_ptr=0; the next request from requester 0 is granted first.
6. With FPMUL_ARB_STATS_EN defined, run test 1 -> busy_cnt=2. With the macro undefined -> busy_cnt=0.
